// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with PC, variable-latency imem handshake and IF/ID register
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        pc_redirect,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        fetch_busy
);
    typedef enum logic [1:0] {FETCH, DRAIN, STALLED} state_t;
    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, saved_target, saved_target_nx, buf_inst, buf_inst_nx;
    logic [31:0] if_id_pc_nx, if_id_inst_nx;
    logic        if_id_valid_nx;
    logic [31:0] pc4, target;
    assign pc4        = pc + 32'd4;
    assign target     = {pc_target[31:2], 2'b00};
    assign imem_addr  = pc;
    assign imem_req   = rst_n && state != STALLED;
    assign fetch_busy = rst_n && state != STALLED && !imem_ready;
    always_comb begin
        state_nx        = state;
        pc_nx           = pc;
        saved_target_nx = saved_target;
        buf_inst_nx     = buf_inst;
        if_id_pc_nx     = if_id_pc;
        if_id_inst_nx   = if_id_inst;
        if_id_valid_nx  = if_id_valid;
        case (state)
            FETCH: begin
                if (!stall && imem_ready) begin
                    if_id_pc_nx    = flush ? if_id_pc : pc4;
                    if_id_inst_nx  = flush ? NOP : imem_rdata;
                    if_id_valid_nx = !flush;
                    pc_nx          = pc_redirect ? target : pc4;
                end else if (!stall) begin
                    if_id_inst_nx  = NOP;
                    if_id_valid_nx = 1'b0;
                    if (pc_redirect) begin
                        saved_target_nx = target;
                        state_nx        = DRAIN;
                    end
                end else if (imem_ready) begin
                    buf_inst_nx = imem_rdata;
                    state_nx    = STALLED;
                end
            end
            DRAIN: begin
                // the in-flight word belongs to the abandoned path and is dropped
                if (!stall) begin
                    if_id_inst_nx  = NOP;
                    if_id_valid_nx = 1'b0;
                    if (pc_redirect) saved_target_nx = target;
                end
                if (imem_ready) begin
                    pc_nx    = (!stall && pc_redirect) ? target : saved_target;
                    state_nx = FETCH;
                end
            end
            default: begin
                if (!stall) begin
                    if_id_pc_nx    = flush ? if_id_pc : pc4;
                    if_id_inst_nx  = flush ? NOP : buf_inst;
                    if_id_valid_nx = !flush;
                    pc_nx          = pc_redirect ? target : pc4;
                    state_nx       = FETCH;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            saved_target <= 32'h0;
            buf_inst     <= 32'h0;
            if_id_pc     <= 32'h0;
            if_id_inst   <= NOP;
            if_id_valid  <= 1'b0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            saved_target <= saved_target_nx;
            buf_inst     <= buf_inst_nx;
            if_id_pc     <= if_id_pc_nx;
            if_id_inst   <= if_id_inst_nx;
            if_id_valid  <= if_id_valid_nx;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector bench for if_stage
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst_n, stall, flush, pc_redirect, imem_ready;
    logic [31:0] pc_target, imem_rdata;
    logic        imem_req, if_id_valid, fetch_busy;
    logic [31:0] imem_addr, if_id_pc, if_id_inst;
    int          n_checks = 0;
    int          n_fails = 0;
    int          cur = -1;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .pc_redirect(pc_redirect), .pc_target(pc_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
        .if_id_valid(if_id_valid), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, stall, flush, redir;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        busy;
        logic [31:0] ipc, iinst;
        logic        ival;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic r, s, f, d, input logic [31:0] t, input logic y,
                       input logic [31:0] rd, input logic q, input logic [31:0] a,
                       input logic b, input logic [31:0] p, i, input logic v);
        vq.push_back('{r, s, f, d, t, y, rd, q, a, b, p, i, v});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s (vector %0d): got %h expected %h", name, cur, act, exp);
        end
    endtask

    initial begin
        // rst stl fl red  target        rdy rdata         req addr         busy ipc           inst          val
        add(1, 0, 0, 0, 32'h0,        1, 32'h0,        1, 32'h0,        0, 32'h4,        32'h0,        1);
        add(1, 0, 0, 0, 32'h0,        1, 32'h4,        1, 32'h4,        0, 32'h8,        32'h4,        1);
        add(1, 1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h8,        0, 32'h8,        32'h4,        1);
        add(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        0, 32'h8,        32'h4,        1);
        add(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        0, 32'h8,        32'h4,        1);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        0, 32'hC,        32'h8,        1);
        add(1, 0, 1, 1, 32'h40,       1, 32'hC,        1, 32'hC,        0, 32'hC,        32'h0,        0);
        add(1, 0, 0, 0, 32'h0,        1, 32'h40,       1, 32'h40,       0, 32'h44,       32'h40,       1);
        add(1, 0, 0, 1, 32'h10,       1, 32'h44,       1, 32'h44,       0, 32'h48,       32'h44,       1);
        add(1, 0, 0, 1, 32'h80,       0, 32'h0,        1, 32'h10,       1, 32'h48,       32'h0,        0);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       1, 32'h48,       32'h0,        0);
        add(1, 0, 0, 0, 32'h0,        1, 32'h10,       1, 32'h10,       0, 32'h48,       32'h0,        0);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80,       1, 32'h48,       32'h0,        0);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h80,       1, 32'h48,       32'h0,        0);
        add(1, 0, 0, 0, 32'h0,        1, 32'h80,       1, 32'h80,       0, 32'h84,       32'h80,       1);
        add(1, 0, 0, 1, 32'hFFFFFFFF, 1, 32'h84,       1, 32'h84,       0, 32'h88,       32'h84,       1);
        add(1, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,        32'hFFFFFFFC, 1);
        add(1, 0, 0, 1, 32'h43,       1, 32'h0,        1, 32'h0,        0, 32'h4,        32'h0,        1);
        add(1, 0, 0, 0, 32'h0,        1, 32'h40,       1, 32'h40,       0, 32'h44,       32'h40,       1);
        add(1, 1, 0, 0, 32'h0,        1, 32'h44,       1, 32'h44,       0, 32'h44,       32'h40,       1);
        add(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h44,       0, 32'h0,        32'h0,        0);
        add(1, 0, 0, 0, 32'h0,        1, 32'h0,        1, 32'h0,        0, 32'h4,        32'h0,        1);
        add(1, 0, 0, 1, 32'h100,      0, 32'h0,        1, 32'h4,        1, 32'h4,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h4,        0, 32'h0,        32'h0,        0);
        add(1, 0, 0, 0, 32'h0,        1, 32'h0,        1, 32'h0,        0, 32'h4,        32'h0,        1);
        add(1, 0, 0, 1, 32'h200,      0, 32'h0,        1, 32'h4,        1, 32'h4,        32'h0,        0);
        add(1, 1, 0, 1, 32'h300,      0, 32'h0,        1, 32'h4,        1, 32'h4,        32'h0,        0);
        add(1, 0, 0, 1, 32'h400,      0, 32'h0,        1, 32'h4,        1, 32'h4,        32'h0,        0);
        add(1, 0, 0, 0, 32'h0,        1, 32'h4,        1, 32'h4,        0, 32'h4,        32'h0,        0);
        add(1, 0, 0, 0, 32'h0,        1, 32'h400,      1, 32'h400,      0, 32'h404,      32'h400,      1);
        add(1, 1, 0, 0, 32'h0,        1, 32'h404,      1, 32'h404,      0, 32'h404,      32'h400,      1);
        add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h404,      0, 32'h404,      32'h0,        0);
        add(1, 0, 0, 0, 32'h0,        1, 32'h408,      1, 32'h408,      0, 32'h40C,      32'h408,      1);

        // power-up reset with data that must not reach IF/ID
        rst_n = 0; stall = 0; flush = 0; pc_redirect = 0; pc_target = 32'h0;
        imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        chk("reset imem_req", {31'b0, imem_req}, 32'h0);
        chk("reset fetch_busy", {31'b0, fetch_busy}, 32'h0);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset if_id_pc", if_id_pc, 32'h0);
        chk("reset if_id_inst", if_id_inst, 32'h0);
        chk("reset if_id_valid", {31'b0, if_id_valid}, 32'h0);

        for (int k = 0; k < vq.size(); k++) begin
            cur = k;
            @(negedge clk);
            rst_n = vq[k].rst_n; stall = vq[k].stall; flush = vq[k].flush;
            pc_redirect = vq[k].redir; pc_target = vq[k].tgt;
            imem_ready = vq[k].rdy; imem_rdata = vq[k].rdata;
            #1;
            chk("imem_req", {31'b0, imem_req}, {31'b0, vq[k].req});
            chk("imem_addr", imem_addr, vq[k].addr);
            chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, vq[k].busy});
            @(posedge clk);
            #1;
            chk("if_id_pc", if_id_pc, vq[k].ipc);
            chk("if_id_inst", if_id_inst, vq[k].iinst);
            chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, vq[k].ival});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
